serial_addsub_acc: RTL and testbench
====================================

# serial_addsub_acc

Parametrised bit-serial adder/subtractor with an internal accumulator, the multi-bit sequential successor to the team's single-bit half adder. Operands are captured in one cycle, then summed LSB-first one bit per enabled clock through a single full-adder cell and a carry flop. Results come with carry-out and signed-overflow flags. The block sits behind the Tiny Tapeout pin wrapper and trades latency for area.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  clock enable; low freezes all state except reset.
- `start`  in  1  request an operation; sampled only in IDLE with `ena`=1.
- `mode`  in  2  operation select: 00 ADD a+b, 01 SUB a−b, 10 ACC acc+b, 11 ACCSUB acc−b.
- `clr`  in  1  clear the accumulator; honoured only in IDLE with `ena`=1.
- `a`  in  WIDTH  operand A; ignored in ACC and ACCSUB modes.
- `b`  in  WIDTH  operand B.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when a result is valid.
- `sum`  out  WIDTH  result of the last completed operation; held until the next `done`.
- `cout`  out  1  carry out of the MSB. For subtract modes, 1 means no borrow.
- `ovf`  out  1  two's-complement overflow of the last result.
- `acc`  out  WIDTH  current accumulator value.

## Operation
- **States.** IDLE and RUN. A bit counter `cnt` runs 0..WIDTH−1.
- **Reset** (`rst_n`=0 at an edge; overrides everything, including mid-RUN):
  - state returns to IDLE;
  - `busy`, `done`, `sum`, `cout`, `ovf` and `acc` all go to 0;
  - `cnt` goes to 0 and the carry flop goes to 0.
- **IDLE, `ena`=1:**
  - If `clr`=1, `acc` is set to 0.
  - If `start`=1:
    - latch the A shift register: `a` for modes 00/01; `acc` for modes 10/11. When `clr` is also 1 that cycle, 0 is latched instead of `acc`.
    - latch the B shift register: `b` for ADD/ACC; `~b` for SUB/ACCSUB.
    - latch the mode and load the carry flop: 1 for SUB/ACCSUB, else 0.
    - set `cnt`=0, go to RUN, and raise `busy`.
- **RUN, `ena`=1, each edge:**
  - `s = A[0] ^ B[0] ^ c`; `c <= maj(A[0], B[0], c)`.
  - `s` shifts into the result register MSB-side, then A and B shift right.
  - `cnt` increments.
  - At `cnt`=WIDTH−1 that edge:
    - `sum` gets the full result, `cout` the final carry.
    - `ovf` = (carry into MSB) ^ (carry out of MSB).
    - `done` = 1 and `busy` = 0; state returns to IDLE.
    - In modes 10/11, `acc` takes the result on the same edge.
- **`ena`=0:** every register holds, including `done`. A `done` pulse in progress stays high until the next enabled edge.
- **Ignored inputs:**
  - `start` and `clr` in RUN are ignored (no queueing).
  - `mode` changes during RUN have no effect.
- **Boundaries:**
  - Wrap-around is modulo 2^WIDTH and is always reported through `cout`/`ovf`.
  - `acc` is never modified by modes 00/01.

## Timing
- Latency: `start` sampled at edge E0, `done` high for the cycle after edge E0+WIDTH (WIDTH+1 enabled edges in total).
- Each cycle with `ena` low during RUN adds exactly one cycle of latency.
- `done` is high for exactly one enabled cycle. It clears on the next enabled edge unless another completion occurs.
- Back-to-back: the cycle in which `done`=1 is IDLE, so `start` in that cycle is accepted. Throughput is one result per WIDTH+1 cycles.
- `sum`, `cout` and `ovf` change only on the completing edge or on reset. They are stable at all other times, including during RUN.
- `busy` rises on the edge after `start` is accepted and falls on the completing edge.

## Test plan
- **Reset.** Reset, then release. Expect all outputs 0. ADD a=0xFF, b=0x01 → `done` at E0+8 with `sum`=0x00, `cout`=1, `ovf`=0.
- **Overflow and borrow.** ADD 0x7F+0x01 → `sum`=0x80, `cout`=0, `ovf`=1. SUB 0x05−0x07 → `sum`=0xFE, `cout`=0, `ovf`=0. SUB 0x80−0x01 → `sum`=0x7F, `cout`=1, `ovf`=1.
- **Accumulate.** `clr`, then three back-to-back ACC ops with b=0x10, each `start` issued in the `done` cycle. Expect `acc`=0x10, 0x20, 0x30 and one `done` every 9 cycles. Then ACCSUB b=0x31 → `acc`=0xFF, `cout`=0.
- **Stall.** ADD 0x12+0x34 with `ena` low for 3 cycles mid-RUN → `done` at E0+11, `sum`=0x46. `start` asserted during RUN is ignored.
- **Clear with start.** `acc`=0x55. `clr`=1 and `start`=1 with ACC and b=0x03 in the same cycle → `sum`=0x03, `acc`=0x03.
- **Reset mid-operation.** Assert `rst_n` low during RUN (cnt=4) → `busy`, `done` and `acc` are 0 next cycle. A new ADD afterwards completes correctly.

Source files
------------

// File: rtl/serial_addsub_acc.sv
// Bit-serial adder/subtractor with accumulator: operands captured in IDLE, then
// summed LSB-first through one full-adder cell and a carry flop, one bit per enabled clock.
module serial_addsub_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [WIDTH-1:0] r_a, w_a_next;
    logic [WIDTH-1:0] r_b, w_b_next;
    logic [WIDTH-1:0] r_res, w_res_next;
    logic             r_c, w_c_next;
    logic             r_acc_mode, w_acc_mode_next;
    logic [WIDTH-1:0] r_sum, w_sum_next;
    logic             r_cout, w_cout_next;
    logic             r_ovf, w_ovf_next;
    logic             r_done, w_done_next;
    logic [WIDTH-1:0] r_acc, w_acc_next;

    logic             w_s;
    logic             w_cmaj;
    logic             w_last;
    logic [WIDTH-1:0] w_result;

    assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cmaj   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_result = {w_s, r_res[WIDTH-1:1]};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_a_next        = r_a;
        w_b_next        = r_b;
        w_res_next      = r_res;
        w_c_next        = r_c;
        w_acc_mode_next = r_acc_mode;
        w_sum_next      = r_sum;
        w_cout_next     = r_cout;
        w_ovf_next      = r_ovf;
        w_done_next     = 1'b0;
        w_acc_next      = r_acc;

        case (r_state)
            S_IDLE: begin
                if (clr) begin
                    w_acc_next = '0;
                end
                if (start) begin
                    // A clear in the same cycle means the accumulate starts from zero
                    w_a_next        = mode[1] ? (clr ? '0 : r_acc) : a;
                    w_b_next        = mode[0] ? ~b : b;
                    w_c_next        = mode[0];
                    w_acc_mode_next = mode[1];
                    w_cnt_next      = '0;
                    w_state_next    = S_RUN;
                end
            end
            S_RUN: begin
                w_c_next   = w_cmaj;
                w_res_next = w_result;
                w_a_next   = r_a >> 1;
                w_b_next   = r_b >> 1;
                w_cnt_next = r_cnt + CW'(1);
                if (w_last) begin
                    w_sum_next   = w_result;
                    w_cout_next  = w_cmaj;
                    // r_c is the carry into the MSB at this point
                    w_ovf_next   = r_c ^ w_cmaj;
                    w_done_next  = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                    if (r_acc_mode) begin
                        w_acc_next = w_result;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_c        <= 1'b0;
            r_acc_mode <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_acc      <= '0;
        end else if (ena) begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_a        <= w_a_next;
            r_b        <= w_b_next;
            r_res      <= w_res_next;
            r_c        <= w_c_next;
            r_acc_mode <= w_acc_mode_next;
            r_sum      <= w_sum_next;
            r_cout     <= w_cout_next;
            r_ovf      <= w_ovf_next;
            r_done     <= w_done_next;
            r_acc      <= w_acc_next;
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign acc  = r_acc;

endmodule

// File: tb/tb_serial_addsub_acc.sv
// Directed bench for serial_addsub_acc: expected results are computed from an
// arithmetic model when each operation is issued and compared when done pulses.
module tb_serial_addsub_acc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic [1:0]   mode;
    logic         clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [W-1:0] acc;

    serial_addsub_acc #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .mode  (mode),
        .clr   (clr),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .acc   (acc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [W-1:0] acc;
        string        tag;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] acc_m;
    logic [W-1:0] last_sum_m;
    int           e0;
    int           done_cyc;
    int           prev_done_cyc;
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Model the operation, push the expectation, and drive start for one enabled edge.
    task automatic issue(input string tag, input logic [1:0] m, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic c);
        exp_t       e;
        logic [W-1:0] x;
        logic [W:0]   full;
        if (c) acc_m = '0;
        x = m[1] ? acc_m : av;
        if (m[0]) full = {1'b0, x} + {1'b0, ~bv} + (W+1)'(1);
        else      full = {1'b0, x} + {1'b0, bv};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        if (m[0]) e.ovf = (x[W-1] != bv[W-1]) && (e.sum[W-1] != x[W-1]);
        else      e.ovf = (x[W-1] == bv[W-1]) && (e.sum[W-1] != x[W-1]);
        if (m[1]) acc_m = e.sum;
        e.acc = acc_m;
        e.tag = tag;
        sb.push_back(e);
        mode = m; a = av; b = bv; clr = c; start = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        start = 1'b0; clr = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_sum_stable"}, sum, last_sum_m);
    endtask

    task automatic wait_done(input int exp_lat);
        exp_t e;
        while (done !== 1'b1 && (cyc - e0) < 4 * W) begin
            @(posedge clk); #1;
        end
        done_cyc = cyc;
        check("done_seen", done, 1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_latency"}, cyc - e0, exp_lat);
            check({e.tag, "_sum"}, sum, e.sum);
            check({e.tag, "_cout"}, cout, e.cout);
            check({e.tag, "_ovf"}, ovf, e.ovf);
            check({e.tag, "_acc"}, acc, e.acc);
            check({e.tag, "_busy_fall"}, busy, 0);
            $display("txn %s: sum=%02h cout=%0b ovf=%0b acc=%02h lat=%0d",
                     e.tag, sum, cout, ovf, acc, cyc - e0);
            last_sum_m = e.sum;
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; mode = 2'b00; clr = 1'b0;
        a = '0; b = '0;
        acc_m = '0; last_sum_m = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_acc", acc, 0);

        issue("add_ff_01", 2'b00, 8'hFF, 8'h01, 1'b0); wait_done(W);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);

        issue("add_7f_01", 2'b00, 8'h7F, 8'h01, 1'b0); wait_done(W);
        issue("sub_05_07", 2'b01, 8'h05, 8'h07, 1'b0); wait_done(W);
        issue("sub_80_01", 2'b01, 8'h80, 8'h01, 1'b0); wait_done(W);
        check("add_sub_no_acc_change", acc, 0);

        // Accumulate: clear, then back-to-back ACC issued in each done cycle
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        acc_m = '0;
        check("clr_acc", acc, 0);
        issue("acc_1", 2'b10, 8'hAA, 8'h10, 1'b0); wait_done(W);
        prev_done_cyc = done_cyc;
        issue("acc_2", 2'b10, 8'hAA, 8'h10, 1'b0); wait_done(W);
        check("acc_interval_1", done_cyc - prev_done_cyc, W + 1);
        prev_done_cyc = done_cyc;
        issue("acc_3", 2'b10, 8'hAA, 8'h10, 1'b0); wait_done(W);
        check("acc_interval_2", done_cyc - prev_done_cyc, W + 1);
        issue("accsub_31", 2'b11, 8'h00, 8'h31, 1'b0); wait_done(W);

        // Stall mid-RUN; start/mode/operand changes during RUN must not matter
        @(posedge clk); #1;
        issue("stall_add", 2'b00, 8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        ena = 1'b0; start = 1'b1; mode = 2'b01; a = 8'hFF; b = 8'hFF;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_busy_hold", busy, 1);
            check("stall_done_low", done, 0);
        end
        ena = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(W + 3);
        ena = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("done_hold_ena_low", done, 1);
        end
        ena = 1'b1;
        @(posedge clk); #1;
        check("done_clear_after_hold", done, 0);
        check("stall_no_requeue", busy, 0);

        // Clear together with start
        issue("acc_to_55", 2'b10, 8'h00, 8'h55, 1'b1); wait_done(W);
        issue("clr_start", 2'b10, 8'h00, 8'h03, 1'b1); wait_done(W);

        // Reset in the middle of an ACC operation at cnt=4
        issue("rst_mid", 2'b10, 8'h00, 8'h07, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        acc_m = '0; last_sum_m = '0;
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check("rstmid_acc", acc, 0);
        check("rstmid_sum", sum, 0);
        issue("add_after_rst", 2'b00, 8'h3C, 8'h5A, 1'b0); wait_done(W);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
